toast_rst_sequencer: RTL and testbench

//  Parametrised clock-domain reset controller for the Toast RV32i core and its test environment.

---
 rtl/toast_rst_pkg.sv | 12 +
 rtl/toast_rst_sync.sv | 22 ++
 rtl/toast_rst_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_toast_rst_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toast_rst_pkg.sv
// Shared types for the Toast reset sequencer: FSM state encoding and its width.
package toast_rst_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_state_e;

endpackage

// File: rtl/toast_rst_sync.sv
// Reset synchroniser: asserts immediately on i_rst, deasserts after SYNC_STAGES clock edges.
module toast_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst_n
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toast_rst_sequencer.sv
// Staggered channel-reset controller for the Toast core with run-cycle counter.
// Optional watchdog (soft reset on missing kicks) is built when TOAST_RST_WDT_EN is defined.
module toast_rst_sequencer
  import toast_rst_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 2,
  parameter int CNT_W          = 32,
  parameter int WDT_CYCLES     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Soft_rst_i,
  input  logic               Kick_i,
  output logic [NUM_CH-1:0]  Rst_n_o,
  output logic               Ready_o,
  output logic [CNT_W-1:0]   Run_cycles_o,
  output logic [STATE_W-1:0] State_o,
  output logic               Wdt_trip_o
);

  localparam int HS_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int HS_W   = $clog2(HS_MAX + 1);
  localparam int CH_W   = $clog2(NUM_CH + 1);

  logic              w_sync_ok;
  logic              w_soft;
  logic              w_wdt_fire;

  rst_state_e        r_state, w_state_nxt;
  logic [HS_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [NUM_CH-1:0] r_rst_n, w_rst_n_nxt;
  logic              r_ready, w_ready_nxt;
  logic [CNT_W-1:0]  r_run, w_run_nxt;

  toast_rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .o_rst_n (w_sync_ok)
  );

`ifdef TOAST_RST_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt, w_wdt_nxt;
  logic             r_trip, w_trip_nxt;

  // Counter only advances in RUN; any other state leaves it cleared.
  always_comb begin
    w_wdt_fire = 1'b0;
    w_wdt_nxt  = '0;
    w_trip_nxt = r_trip;
    if (r_state == RUN) begin
      if (Kick_i) begin
        w_wdt_nxt = '0;
      end else if (r_wdt == WDT_W'(WDT_CYCLES - 1)) begin
        w_wdt_fire = 1'b1;
        w_trip_nxt = 1'b1;
      end else begin
        w_wdt_nxt = r_wdt + WDT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wdt  <= '0;
      r_trip <= 1'b0;
    end else begin
      r_wdt  <= w_wdt_nxt;
      r_trip <= w_trip_nxt;
    end
  end

  assign Wdt_trip_o = r_trip;
`else
  logic        w_unused_kick;
  logic [31:0] w_unused_wdt;

  assign w_unused_kick = Kick_i;
  assign w_unused_wdt  = 32'(WDT_CYCLES);
  assign w_wdt_fire    = 1'b0;
  assign Wdt_trip_o    = 1'b0;
`endif

  assign w_soft = Soft_rst_i | w_wdt_fire;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_rst_n_nxt = r_rst_n;
    w_ready_nxt = r_ready;
    w_run_nxt   = r_run;

    case (r_state)
      HOLD: begin
        // Hold count only starts once the synchronised reset has dropped.
        if (!w_sync_ok || w_soft) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HS_W'(HOLD_CYCLES - 1)) begin
          w_cnt_nxt      = '0;
          w_rst_n_nxt[0] = 1'b1;
          w_ch_nxt       = CH_W'(1);
          w_state_nxt    = RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + HS_W'(1);
        end
      end

      RELEASE: begin
        if (w_soft) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_run_nxt   = '0;
        end else if (r_ch == CH_W'(NUM_CH)) begin
          w_state_nxt = RUN;
          w_ready_nxt = 1'b1;
        end else if (r_cnt == HS_W'(STAGGER_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == r_ch) begin
              w_rst_n_nxt[k] = 1'b1;
            end
          end
          w_ch_nxt = r_ch + CH_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + HS_W'(1);
        end
      end

      RUN: begin
        if (w_soft) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
          w_rst_n_nxt = '0;
          w_ready_nxt = 1'b0;
          w_run_nxt   = '0;
        end else if (r_run != '1) begin
          w_run_nxt = r_run + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = '0;
        w_ch_nxt    = '0;
        w_rst_n_nxt = '0;
        w_ready_nxt = 1'b0;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_ready <= w_ready_nxt;
      r_run   <= w_run_nxt;
    end
  end

  assign Rst_n_o      = r_rst_n;
  assign Ready_o      = r_ready;
  assign Run_cycles_o = r_run;
  assign State_o      = r_state;

endmodule

// File: tb/tb_toast_rst_sequencer.sv
// Directed bench for toast_rst_sequencer: default instance plus a NUM_CH=1/CNT_W=4 instance.
module tb_toast_rst_sequencer;

  logic        Clk    = 1'b0;
  logic        Reset  = 1'b1;
  logic        Reset1 = 1'b1;
  logic        Soft   = 1'b0;
  logic        Kick   = 1'b0;

  logic [2:0]  rst_n;
  logic        ready;
  logic [31:0] run;
  logic [1:0]  state;
  logic        trip;

  logic [0:0]  rst_n1;
  logic        ready1;
  logic [3:0]  run1;
  logic [1:0]  state1;
  logic        trip1;

  int n_cmp  = 0;
  int n_mis  = 0;
  int edge_n = 0;

  always #5 Clk = ~Clk;

  toast_rst_sequencer u_dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Soft_rst_i   (Soft),
    .Kick_i       (Kick),
    .Rst_n_o      (rst_n),
    .Ready_o      (ready),
    .Run_cycles_o (run),
    .State_o      (state),
    .Wdt_trip_o   (trip)
  );

  toast_rst_sequencer #(
    .NUM_CH      (1),
    .HOLD_CYCLES (1),
    .CNT_W       (4)
  ) u_dut1 (
    .Clk          (Clk),
    .Reset        (Reset1),
    .Soft_rst_i   (1'b0),
    .Kick_i       (1'b1),
    .Rst_n_o      (rst_n1),
    .Ready_o      (ready1),
    .Run_cycles_o (run1),
    .State_o      (state1),
    .Wdt_trip_o   (trip1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    edge_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_rst();
    @(negedge Clk);
    Reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    edge_n = 0;
  endtask

  // Expected waveform after release: [0]@6, [1]@8, [2]@10, Ready@11, Run=1@12.
  task automatic check_seq(input string tag, input int last_e);
    logic [2:0] er;
    logic [1:0] es;
    for (int e = 1; e <= last_e; e++) begin
      tick();
      er = (e >= 10) ? 3'b111 : (e >= 8) ? 3'b011 : (e >= 6) ? 3'b001 : 3'b000;
      es = (e >= 11) ? 2'd2 : (e >= 6) ? 2'd1 : 2'd0;
      check_eq($sformatf("%s_e%0d_rstn", tag, e), 32'(rst_n), 32'(er));
      check_eq($sformatf("%s_e%0d_ready", tag, e), 32'(ready), 32'(e >= 11));
      check_eq($sformatf("%s_e%0d_state", tag, e), 32'(state), 32'(es));
      check_eq($sformatf("%s_e%0d_run", tag, e), run, (e >= 12) ? 32'(e - 11) : 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    ticks(2);
    check_eq("rst_rstn",  32'(rst_n), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_run",   run,        32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_trip",  32'(trip),  32'd0);

    // Basic release sequence
    release_rst();
    check_seq("t1", 12);

    // Asynchronous reset mid-RELEASE
    pulse_reset();
    check_seq("t2a", 8);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("t2_async_rstn",  32'(rst_n), 32'd0);
    check_eq("t2_async_ready", 32'(ready), 32'd0);
    check_eq("t2_async_state", 32'(state), 32'd0);
    release_rst();
    check_seq("t2b", 12);

    // Soft reset pulse in RUN
    ticks(19);
    check_eq("t3_run20", run, 32'd20);
    @(negedge Clk);
    Soft = 1'b1;
    tick();
    check_eq("t3_p_rstn",  32'(rst_n), 32'd0);
    check_eq("t3_p_run",   run,        32'd0);
    check_eq("t3_p_ready", 32'(ready), 32'd0);
    check_eq("t3_p_state", 32'(state), 32'd0);
    @(negedge Clk);
    Soft = 1'b0;
    ticks(3);
    check_eq("t3_p3_rstn", 32'(rst_n), 32'd0);
    tick();
    check_eq("t3_p4_rstn", 32'(rst_n), 32'd1);
    ticks(4);
    check_eq("t3_p8_rstn",  32'(rst_n), 32'd7);
    check_eq("t3_p8_ready", 32'(ready), 32'd0);
    tick();
    check_eq("t3_p9_ready", 32'(ready), 32'd1);
    check_eq("t3_p9_state", 32'(state), 32'd2);

    // Soft reset coinciding with the channel-1 release, then held in HOLD
    pulse_reset();
    ticks(7);
    check_eq("t7_e7_rstn", 32'(rst_n), 32'd1);
    @(negedge Clk);
    Soft = 1'b1;
    tick();
    check_eq("t7_e8_rstn",  32'(rst_n), 32'd0);
    check_eq("t7_e8_state", 32'(state), 32'd0);
    ticks(2);
    check_eq("t7_e10_rstn",  32'(rst_n), 32'd0);
    check_eq("t7_e10_state", 32'(state), 32'd0);
    @(negedge Clk);
    Soft = 1'b0;
    ticks(3);
    check_eq("t7_e13_rstn", 32'(rst_n), 32'd0);
    tick();
    check_eq("t7_e14_rstn",  32'(rst_n), 32'd1);
    check_eq("t7_e14_state", 32'(state), 32'd1);

    // Watchdog timeout with Kick held low
    pulse_reset();
    Kick = 1'b0;
    ticks(26);
    check_eq("t5_e26_rstn", 32'(rst_n), 32'd7);
    check_eq("t5_e26_trip", 32'(trip),  32'd0);
    check_eq("t5_e26_run",  run,        32'd15);
    tick();
`ifdef TOAST_RST_WDT_EN
    check_eq("t5_e27_trip",  32'(trip),  32'd1);
    check_eq("t5_e27_rstn",  32'(rst_n), 32'd0);
    check_eq("t5_e27_state", 32'(state), 32'd0);
    check_eq("t5_e27_run",   run,        32'd0);
    ticks(4);
    check_eq("t5_e31_rstn", 32'(rst_n), 32'd1);
    check_eq("t5_e31_trip", 32'(trip),  32'd1);
    ticks(30);
    check_eq("t5_e61_trip", 32'(trip), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_eq("t5_reset_trip", 32'(trip), 32'd0);

    // Periodic kicks prevent a trip
    @(negedge Clk);
    Reset  = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 210; i++) begin
      @(negedge Clk);
      Kick = ((edge_n + 1) >= 20 && ((edge_n + 1) % 10) == 0);
      tick();
    end
    Kick = 1'b0;
    check_eq("t6_trip",  32'(trip),  32'd0);
    check_eq("t6_rstn",  32'(rst_n), 32'd7);
    check_eq("t6_ready", 32'(ready), 32'd1);
    check_eq("t6_run",   run,        32'd199);
`else
    check_eq("t5_e27_trip", 32'(trip),  32'd0);
    check_eq("t5_e27_rstn", 32'(rst_n), 32'd7);
    check_eq("t5_e27_run",  run,        32'd16);
`endif

    // Single-channel instance, HOLD_CYCLES=1, 4-bit saturating counter
    check_eq("t4_rst_rstn",  32'(rst_n1), 32'd0);
    check_eq("t4_rst_ready", 32'(ready1), 32'd0);
    check_eq("t4_rst_run",   32'(run1),   32'd0);
    check_eq("t4_rst_trip",  32'(trip1),  32'd0);
    @(negedge Clk);
    Reset1 = 1'b0;
    edge_n = 0;
    ticks(2);
    check_eq("t4_e2_rstn", 32'(rst_n1), 32'd0);
    tick();
    check_eq("t4_e3_rstn",  32'(rst_n1), 32'd1);
    check_eq("t4_e3_ready", 32'(ready1), 32'd0);
    check_eq("t4_e3_state", 32'(state1), 32'd1);
    tick();
    check_eq("t4_e4_ready", 32'(ready1), 32'd1);
    check_eq("t4_e4_state", 32'(state1), 32'd2);
    check_eq("t4_e4_run",   32'(run1),   32'd0);
    tick();
    check_eq("t4_e5_run", 32'(run1), 32'd1);
    ticks(13);
    check_eq("t4_e18_run", 32'(run1), 32'd14);
    tick();
    check_eq("t4_e19_run", 32'(run1), 32'd15);
    ticks(10);
    check_eq("t4_e29_run",   32'(run1),   32'd15);
    check_eq("t4_e29_ready", 32'(ready1), 32'd1);
    check_eq("t4_e29_rstn",  32'(rst_n1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
